// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: decoder control bundle, RAM access widths, register constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    // Memory access width codes carried in ram_sel.
    localparam logic [1:0] RAM_WORD = 2'b00;
    localparam logic [1:0] RAM_HALF = 2'b01;
    localparam logic [1:0] RAM_BYTE = 2'b10;

    // Link register written by jal.
    localparam logic [4:0] REG_RA = 5'd31;

    // All decoder control points, shared by decoder, ID/EX and EX/MEM.
    typedef struct packed {
        logic       beq;
        logic       bne;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       signed_ext;
        logic       jal;
        logic       jmp;
        logic       jr;
        logic       syscall;
        logic       shamt_sel;
        logic       sp_branch;
        logic [3:0] alu_op;
        logic [1:0] ram_sel;
    } ctrl_t;

    // A bubble carries no side effects: every control point is zero.
    localparam ctrl_t CTRL_BUBBLE = '0;

    // Operands and instruction fields travelling with the control bundle.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm_ext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
    } data_t;

    localparam data_t DATA_ZERO = '0;

    // Destination register: jal links to $ra, R-type uses rd, everything else rt.
    function automatic logic [4:0] dest_reg(input ctrl_t c, input logic [4:0] rt,
                                            input logic [4:0] rd);
        if (c.jal)
            return REG_RA;
        else if (c.reg_dst)
            return rd;
        else
            return rt;
    endfunction

endpackage

// File: rtl/id_ex_register_if.sv
// ID/EX boundary bundle: stall/flush controls, decoder-side id_* signals, EX-side ex_* signals.
// Ports: master = ID side (drives id_*, stall, flush); slave = ID/EX register (drives ex_*, load_use).
// Backpressure: load_use tells the upstream PC and IF/ID to hold in the same cycle.
interface id_ex_register_if;
    logic        stall, flush;

    logic        id_valid;
    logic        id_beq, id_bne, id_mem_to_reg, id_mem_write, id_alu_src_b, id_reg_write;
    logic        id_reg_dst, id_signed_ext, id_jal, id_jmp, id_jr, id_syscall;
    logic        id_shamt_sel, id_sp_branch;
    logic [3:0]  id_alu_op;
    logic [1:0]  id_ram_sel;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm_ext;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;

    logic        ex_valid;
    logic        ex_beq, ex_bne, ex_mem_to_reg, ex_mem_write, ex_alu_src_b, ex_reg_write;
    logic        ex_reg_dst, ex_signed_ext, ex_jal, ex_jmp, ex_jr, ex_syscall;
    logic        ex_shamt_sel, ex_sp_branch;
    logic [3:0]  ex_alu_op;
    logic [1:0]  ex_ram_sel;
    logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm_ext;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [4:0]  ex_wr_addr;

    logic        load_use;

    modport master (
        output stall, flush, id_valid,
        output id_beq, id_bne, id_mem_to_reg, id_mem_write, id_alu_src_b, id_reg_write,
        output id_reg_dst, id_signed_ext, id_jal, id_jmp, id_jr, id_syscall,
        output id_shamt_sel, id_sp_branch, id_alu_op, id_ram_sel,
        output id_pc, id_rs_data, id_rt_data, id_imm_ext, id_rs, id_rt, id_rd, id_shamt,
        input  ex_valid,
        input  ex_beq, ex_bne, ex_mem_to_reg, ex_mem_write, ex_alu_src_b, ex_reg_write,
        input  ex_reg_dst, ex_signed_ext, ex_jal, ex_jmp, ex_jr, ex_syscall,
        input  ex_shamt_sel, ex_sp_branch, ex_alu_op, ex_ram_sel,
        input  ex_pc, ex_rs_data, ex_rt_data, ex_imm_ext, ex_rs, ex_rt, ex_rd, ex_shamt,
        input  ex_wr_addr, load_use
    );

    modport slave (
        input  stall, flush, id_valid,
        input  id_beq, id_bne, id_mem_to_reg, id_mem_write, id_alu_src_b, id_reg_write,
        input  id_reg_dst, id_signed_ext, id_jal, id_jmp, id_jr, id_syscall,
        input  id_shamt_sel, id_sp_branch, id_alu_op, id_ram_sel,
        input  id_pc, id_rs_data, id_rt_data, id_imm_ext, id_rs, id_rt, id_rd, id_shamt,
        output ex_valid,
        output ex_beq, ex_bne, ex_mem_to_reg, ex_mem_write, ex_alu_src_b, ex_reg_write,
        output ex_reg_dst, ex_signed_ext, ex_jal, ex_jmp, ex_jr, ex_syscall,
        output ex_shamt_sel, ex_sp_branch, ex_alu_op, ex_ram_sel,
        output ex_pc, ex_rs_data, ex_rt_data, ex_imm_ext, ex_rs, ex_rt, ex_rd, ex_shamt,
        output ex_wr_addr, load_use
    );
endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: instruction in EX is a load whose result ID needs now.
// Latency: 0 (purely combinational). Ports: EX-side load/dest info in, ID rs/rt in, load_use out.
// Backpressure: load_use is the hold request itself; rt compare is unconditional (conservative).
module hazard_detect (
    input  logic       ex_valid,
    input  logic       ex_mem_to_reg,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_wr_addr,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       load_use
);
    // $0 is never a real dependency, so a load targeting it cannot cause a hazard.
    assign load_use = ex_valid & ex_mem_to_reg & ex_reg_write & (ex_wr_addr != 5'd0) &
                      id_valid & ((ex_wr_addr == id_rs) | (ex_wr_addr == id_rt));
endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
// Latency: 1 cycle id_* -> ex_*. Ports: clk, rst, bus (slave side), bubble_cnt.
// Backpressure: stall freezes everything; flush or load_use captures a bubble instead of ID.
module id_ex_register
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    id_ex_register_if.slave       bus,
    output logic [CNT_W-1:0]      bubble_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t      id_ctrl, ex_ctrl;
    data_t      id_data, ex_data;
    logic       ex_valid;
    logic [4:0] ex_wr_addr;
    logic       load_use;

    assign id_ctrl = '{
        beq:        bus.id_beq,        bne:        bus.id_bne,
        mem_to_reg: bus.id_mem_to_reg, mem_write:  bus.id_mem_write,
        alu_src_b:  bus.id_alu_src_b,  reg_write:  bus.id_reg_write,
        reg_dst:    bus.id_reg_dst,    signed_ext: bus.id_signed_ext,
        jal:        bus.id_jal,        jmp:        bus.id_jmp,
        jr:         bus.id_jr,         syscall:    bus.id_syscall,
        shamt_sel:  bus.id_shamt_sel,  sp_branch:  bus.id_sp_branch,
        alu_op:     bus.id_alu_op,     ram_sel:    bus.id_ram_sel
    };

    assign id_data = '{
        pc:      bus.id_pc,      rs_data: bus.id_rs_data,
        rt_data: bus.id_rt_data, imm_ext: bus.id_imm_ext,
        rs:      bus.id_rs,      rt:      bus.id_rt,
        rd:      bus.id_rd,      shamt:   bus.id_shamt
    };

    hazard_detect u_hazard (
        .ex_valid      (ex_valid),
        .ex_mem_to_reg (ex_ctrl.mem_to_reg),
        .ex_reg_write  (ex_ctrl.reg_write),
        .ex_wr_addr    (ex_wr_addr),
        .id_valid      (bus.id_valid),
        .id_rs         (bus.id_rs),
        .id_rt         (bus.id_rt),
        .load_use      (load_use)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= CTRL_BUBBLE;
            ex_data    <= DATA_ZERO;
            ex_wr_addr <= 5'd0;
            bubble_cnt <= '0;
        end else if (!bus.stall) begin
            if (bus.flush || load_use) begin
                // Flush and load-use in the same cycle still make one bubble, one count.
                ex_valid   <= 1'b0;
                ex_ctrl    <= CTRL_BUBBLE;
                ex_data    <= DATA_ZERO;
                ex_wr_addr <= 5'd0;
                if (bubble_cnt != CNT_MAX)
                    bubble_cnt <= bubble_cnt + 1'b1;
            end else begin
                ex_valid   <= bus.id_valid;
                ex_ctrl    <= id_ctrl;
                ex_data    <= id_data;
                ex_wr_addr <= dest_reg(id_ctrl, bus.id_rt, bus.id_rd);
            end
        end
    end

    assign bus.load_use      = load_use;
    assign bus.ex_valid      = ex_valid;
    assign bus.ex_wr_addr    = ex_wr_addr;
    assign bus.ex_beq        = ex_ctrl.beq;
    assign bus.ex_bne        = ex_ctrl.bne;
    assign bus.ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign bus.ex_mem_write  = ex_ctrl.mem_write;
    assign bus.ex_alu_src_b  = ex_ctrl.alu_src_b;
    assign bus.ex_reg_write  = ex_ctrl.reg_write;
    assign bus.ex_reg_dst    = ex_ctrl.reg_dst;
    assign bus.ex_signed_ext = ex_ctrl.signed_ext;
    assign bus.ex_jal        = ex_ctrl.jal;
    assign bus.ex_jmp        = ex_ctrl.jmp;
    assign bus.ex_jr         = ex_ctrl.jr;
    assign bus.ex_syscall    = ex_ctrl.syscall;
    assign bus.ex_shamt_sel  = ex_ctrl.shamt_sel;
    assign bus.ex_sp_branch  = ex_ctrl.sp_branch;
    assign bus.ex_alu_op     = ex_ctrl.alu_op;
    assign bus.ex_ram_sel    = ex_ctrl.ram_sel;
    assign bus.ex_pc         = ex_data.pc;
    assign bus.ex_rs_data    = ex_data.rs_data;
    assign bus.ex_rt_data    = ex_data.rt_data;
    assign bus.ex_imm_ext    = ex_data.imm_ext;
    assign bus.ex_rs         = ex_data.rs;
    assign bus.ex_rt         = ex_data.rt;
    assign bus.ex_rd         = ex_data.rd;
    assign bus.ex_shamt      = ex_data.shamt;
endmodule
